// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scroller: FSM states, LFSR polynomial/seed,
// and the LFSR step / tap-rotation helpers.
package obstacle_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED
  } state_e;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h1ACE;
  localparam int unsigned Y_MIN_DEF = 64;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned sh);
    logic [31:0] t;
    t = {v, v} << (sh % 16);
    return t[31:16];
  endfunction

endpackage

// File: rtl/lfsr_height.sv
// Free-running 16-bit LFSR mapped to one gap height per channel; channel i sees the
// LFSR rotated left by 3*i so simultaneous respawns get different heights.
module lfsr_height
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_OBS = 3,
  parameter int unsigned Y_W     = 9,
  parameter int unsigned Y_MIN   = Y_MIN_DEF,
  parameter int unsigned Y_RANGE = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [NUM_OBS*Y_W-1:0] height_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_height
    logic [31:0] rot32;
    assign rot32 = {16'h0000, rotl16(lfsr_q, 3 * g)};
    assign height_o[g*Y_W +: Y_W] = Y_W'((rot32 % Y_RANGE) + Y_MIN);
  end

endmodule

// File: rtl/obstacle_scroller.sv
// Multi-channel horizontal obstacle scroller with tick-enabled motion and random respawn.
// Optional SCROLL_ACCEL_EN adds a pass-count speed bonus on top of the speed input.
module obstacle_scroller
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_OBS  = 3,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned OBS_W    = 32,
  parameter int unsigned SPACING  = 224,
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned Y_MIN    = Y_MIN_DEF,
  parameter int unsigned Y_RANGE  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic [3:0]             speed,
  output logic [NUM_OBS*X_W-1:0] x_out,
  output logic [NUM_OBS*Y_W-1:0] y_out,
  output logic [NUM_OBS-1:0]     pass_p,
  output logic                   running
);

  localparam int unsigned CNT_W    = $clog2(TICK_DIV);
  localparam logic [X_W:0] TRACK_X = (X_W+1)'(SCREEN_W + OBS_W);

  state_e             state_q, state_d;
  logic               running_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [3:0]         eff_speed;
  logic [NUM_OBS*Y_W-1:0] new_height;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)  state_d = S_RUN;
      S_RUN:    if (pause)  state_d = S_PAUSED;
      S_PAUSED: if (!pause) state_d = S_RUN;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign running = running_q;

  // Tick counter only advances while running, so pausing preserves the tick phase.
  assign tick = (state_q == S_RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_RUN) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

`ifdef SCROLL_ACCEL_EN
  logic [3:0] pass_cnt_q, pass_cnt_d;

  always_comb begin
    logic [4:0] sum;
    sum = {1'b0, pass_cnt_q};
    for (int i = 0; i < NUM_OBS; i++) sum = sum + 5'(pass_p[i]);
    if (state_q == S_IDLE)  pass_cnt_d = '0;
    else if (sum > 5'd15)   pass_cnt_d = 4'hF;
    else                    pass_cnt_d = sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) pass_cnt_q <= '0;
    else     pass_cnt_q <= pass_cnt_d;
  end

  // Bonus of one pixel once eight passes are seen, never pushing the speed past 15.
  assign eff_speed = (speed == 4'hF) ? speed : speed + {3'b000, pass_cnt_q[3]};
`else
  assign eff_speed = speed;
`endif

  lfsr_height #(
    .NUM_OBS (NUM_OBS),
    .Y_W     (Y_W),
    .Y_MIN   (Y_MIN),
    .Y_RANGE (Y_RANGE)
  ) u_lfsr_height (
    .clk      (clk),
    .rst      (rst),
    .height_o (new_height)
  );

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_chan
    // Start positions beyond the X_W range fold modulo 2**X_W.
    localparam logic [X_W-1:0] X_RST = X_W'(SCREEN_W + g * SPACING);
    localparam logic [Y_W-1:0] Y_RST = Y_W'(Y_MIN + g * 16);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           pass_q, pass_d;
    logic [X_W:0]   x_ext, spd_ext;

    assign x_ext   = {1'b0, x_q};
    assign spd_ext = (X_W+1)'(eff_speed);

    always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      pass_d = 1'b0;
      if (tick) begin
        if (x_ext >= spd_ext) begin
          x_d = X_W'(x_ext - spd_ext);
        end else begin
          x_d    = X_W'(x_ext + TRACK_X - spd_ext);
          y_d    = new_height[g*Y_W +: Y_W];
          pass_d = 1'b1;
        end
      end
    end

    // NOTE: reset is synchronous, so it only takes effect on a clock edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        x_q    <= X_RST;
        y_q    <= Y_RST;
        pass_q <= 1'b0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        pass_q <= pass_d;
      end
    end

    assign x_out[g*X_W +: X_W] = x_q;
    assign y_out[g*Y_W +: Y_W] = y_q;
    assign pass_p[g]           = pass_q;
  end

endmodule
